// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready stage bus; in_* faces upstream, out_* faces downstream; slave = stage view, master = environment view
interface pipe_stage_skid_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage (skid or single register); ports clk, reset (sync active-low), flush, bus (slave handshake), occupancy
module pipe_stage_skid #(
  parameter int          WIDTH      = 32,
  parameter bit          SKID       = 1'b1,
  parameter logic [31:0] BUBBLE_VAL = 32'h00000013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  pipe_stage_skid_if.slave    bus,
  output logic [1:0]          occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  localparam logic [WIDTH-1:0] BV = WIDTH'(BUBBLE_VAL);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             in_fire, out_fire;
  assign bus.in_ready  = reset & (SKID ? (state_q != FULL) : (state_q == EMPTY || bus.out_ready));
  assign bus.out_valid = state_q != EMPTY;
  assign bus.out_data  = main_q;
  assign occupancy     = state_q;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BV;
      skid_d  = BV;
    end else if (SKID) begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          main_d  = bus.in_data;
        end
        ONE: if (in_fire && out_fire) begin
          main_d = bus.in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = BV;
        end
        FULL: if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BV;
        end
        default: state_d = EMPTY;
      endcase
    end else if (in_fire) begin
      state_d = ONE;
      main_d  = bus.in_data;
    end else if (out_fire) begin
      state_d = EMPTY;
      main_d  = BV;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= BV;
      skid_q  <= BV;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule
